// File: rtl/rx_fifo_pkg.sv
// Shared types and constants for the receive FIFO arbiter: length-entry layout,
// data word tags, FSM state encoding and the word-count helper.
package rx_fifo_pkg;

   localparam int          LEN_FRAME_BIT = 17;
   localparam logic [15:0] HDR_BYTES     = 16'd8;
   localparam logic [1:0]  TAG_HDR       = 2'b11;
   localparam logic [1:0]  TAG_DATA      = 2'b10;

   typedef enum logic [1:0] {IDLE, GRANT, FWD, DROP} state_t;

   // 17-bit result so a 16'hFFFF byte count rounds up without wrapping
   function automatic logic [16:0] word_count(input logic [15:0] len);
      return ({1'b0, len} + 17'd1) >> 1;
   endfunction

endpackage

// File: rtl/rx_fifo_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first requesting
// index at or after ptr, wrapping around N requesters.
module rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any
);

   logic [N-1:0] rotated;
   logic [N-1:0] scan;
   logic [W:0]   offset;
   logic [W:0]   sum;

   // rotate so bit 0 is the requester sitting at ptr
   assign rotated = N'({req, req} >> ptr);

   always_comb begin
      scan   = rotated;
      offset = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && scan[0]) begin
            offset = (W+1)'(i);
            any    = 1'b1;
         end
         scan = scan >> 1;
      end
      sum = {1'b0, ptr} + offset;
      if (sum >= (W+1)'(N))
         sum = sum - (W+1)'(N);
      grant = sum[W-1:0];
   end

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin drain of per-port length/data FIFO pairs into one framed stream.
// Optional per-port statistics counters are enabled with RX_FIFO_ARBITER_STATS_EN.
module rx_fifo_arbiter
   import rx_fifo_pkg::*;
#(
   parameter int          PORTS   = 2,
   parameter int          PW      = 1,
   parameter logic [15:0] MIN_LEN = HDR_BYTES
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [18*PORTS-1:0] len_dout,
   input  logic [PORTS-1:0]    len_empty,
   output logic [PORTS-1:0]    len_rd_en,
   input  logic [18*PORTS-1:0] data_dout,
   input  logic [PORTS-1:0]    data_empty,
   output logic [PORTS-1:0]    data_rd_en,
   output logic [17:0]         out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sof,
   output logic                out_eof,
   output logic [PW-1:0]       out_port,
   output logic [15:0]         out_len,
   output logic                err_pulse
`ifdef RX_FIFO_ARBITER_STATS_EN
   ,
   output logic [32*PORTS-1:0] stat_frames,
   output logic [32*PORTS-1:0] stat_gaps,
   output logic [32*PORTS-1:0] stat_errs
`endif
);

   state_t        state;
   logic [PW-1:0] sel;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] pick;
   logic [PW-1:0] next_ptr;
   logic          any;
   logic [16:0]   remaining;
   logic          first;
   logic          is_gap;
   logic [17:0]   len_arr  [PORTS];
   logic [17:0]   data_arr [PORTS];
   logic [17:0]   head_len;
   logic [16:0]   head_wc;
   logic          head_gap;
   logic          head_short;
   logic          last_word;
   logic          xfer;

   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_split
         assign len_arr[gi]  = len_dout[18*gi +: 18];
         assign data_arr[gi] = data_dout[18*gi +: 18];
      end
   endgenerate

   rr_pick #(.N(PORTS), .W(PW)) u_pick (
      .req   (~len_empty),
      .ptr   (rr_ptr),
      .grant (pick),
      .any   (any)
   );

   assign head_len   = len_arr[sel];
   assign head_wc    = word_count(head_len[15:0]);
   assign head_gap   = !head_len[LEN_FRAME_BIT];
   assign head_short = head_len[15:0] < MIN_LEN;
   assign last_word  = remaining == 17'd1;
   assign next_ptr   = (int'(sel) == PORTS - 1) ? '0 : sel + 1'b1;
   assign xfer       = out_valid & out_ready;

   // Strobes are decoded from state so an async reset clears them immediately
   always_comb begin
      len_rd_en  = '0;
      data_rd_en = '0;
      out_valid  = 1'b0;
      out_sof    = 1'b0;
      out_eof    = 1'b0;
      err_pulse  = 1'b0;
      out_data   = '0;
      case (state)
         GRANT: begin
            len_rd_en[sel] = 1'b1;
            err_pulse      = !head_gap && head_short;
         end
         FWD: begin
            out_valid       = !data_empty[sel];
            out_data        = data_arr[sel];
            data_rd_en[sel] = !data_empty[sel] && out_ready;
            out_sof         = !data_empty[sel] && first;
            out_eof         = !data_empty[sel] && last_word;
         end
         DROP: data_rd_en[sel] = !data_empty[sel];
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         sel       <= '0;
         out_port  <= '0;
         out_len   <= '0;
         remaining <= '0;
         first     <= 1'b0;
         is_gap    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  sel   <= pick;
                  state <= GRANT;
               end
            end
            GRANT: begin
               out_len  <= head_len[15:0];
               out_port <= sel;
               first    <= 1'b1;
               is_gap   <= head_gap;
               if (head_gap) begin
                  remaining <= 17'd1;
                  state     <= DROP;
               end else if (head_short) begin
                  remaining <= head_wc;
                  if (head_wc == '0) begin
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                  end else begin
                     state <= DROP;
                  end
               end else begin
                  remaining <= head_wc;
                  state     <= FWD;
               end
            end
            FWD: begin
               if (xfer) begin
                  first     <= 1'b0;
                  remaining <= remaining - 17'd1;
                  if (last_word) begin
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                  end
               end
            end
            DROP: begin
               if (!data_empty[sel]) begin
                  remaining <= remaining - 17'd1;
                  if (last_word) begin
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RX_FIFO_ARBITER_STATS_EN
   logic frame_done;
   logic gap_done;

   assign frame_done = xfer && last_word;
   assign gap_done   = (state == DROP) && is_gap && !data_empty[sel] && last_word;

   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_stats
         logic        hit;
         logic [31:0] frames_cnt;
         logic [31:0] gaps_cnt;
         logic [31:0] errs_cnt;

         assign hit = sel == PW'(gi);
         assign stat_frames[32*gi +: 32] = frames_cnt;
         assign stat_gaps[32*gi +: 32]   = gaps_cnt;
         assign stat_errs[32*gi +: 32]   = errs_cnt;

         // counters saturate at all-ones instead of wrapping
         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
               frames_cnt <= '0;
               gaps_cnt   <= '0;
               errs_cnt   <= '0;
            end else begin
               if (hit && frame_done && frames_cnt != '1)
                  frames_cnt <= frames_cnt + 32'd1;
               if (hit && gap_done && gaps_cnt != '1)
                  gaps_cnt <= gaps_cnt + 32'd1;
               if (hit && err_pulse && errs_cnt != '1)
                  errs_cnt <= errs_cnt + 32'd1;
            end
         end
      end
   endgenerate
`endif

endmodule
